active_list: RTL and testbench

//  In-order retirement counterpart of the out-of-order instruction queue.
//  - Allocates a 5-bit active-list index per dispatched instruction; the queue carries this as its

---
 rtl/active_list_pkg.sv | 27 ++
 rtl/active_list.sv | 151 +++++++++++++++
 tb/tb_active_list.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/active_list_pkg.sv
// Shared types for the active list: index, physical tag, FSM state and entry payload.
package active_list_pkg;

    localparam int DEPTH  = 32;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int PREG_W = 6;

    typedef logic [IDX_W-1:0]  ActiveListIdx;
    typedef logic [CNT_W-1:0]  AlCount;
    typedef logic [PREG_W-1:0] PhysReg;
    typedef logic [4:0]        MipsReg;

    typedef enum logic {AL_RUN, AL_WALK} AlState;

    // Payload captured at dispatch; the valid/done/mispredict status bits live
    // in separate resettable vectors.
    typedef struct packed {
        logic   uses_rw;
        MipsReg arch_rd;
        PhysReg new_preg;
        PhysReg old_preg;
        logic   is_branch;
        logic   is_store;
    } ActiveListEntry;

endpackage

// File: rtl/active_list.sv
// In-order retirement buffer: allocates indices at dispatch, marks completion
// from writeback, retires from the head, and on a mispredicted branch walks back
// from the tail restoring the rename map one entry per cycle.
module active_list
    import active_list_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         alloc_valid,
    output logic         alloc_ready,
    output ActiveListIdx alloc_index,
    input  logic         alloc_uses_rw,
    input  MipsReg       alloc_arch_rd,
    input  PhysReg       alloc_new_preg,
    input  PhysReg       alloc_old_preg,
    input  logic         alloc_is_branch,
    input  logic         alloc_is_store,
    input  logic         wb_valid,
    input  ActiveListIdx wb_index,
    input  logic         wb_mispredict,
    output logic         commit_valid,
    output ActiveListIdx commit_index,
    output logic         commit_uses_rw,
    output MipsReg       commit_arch_rd,
    output logic         commit_is_store,
    output logic         free_valid,
    output PhysReg       free_preg,
    output logic         rollback_valid,
    output MipsReg       rollback_arch_rd,
    output PhysReg       rollback_preg,
    output logic         flush
);

    AlState           r_state, w_state_next;
    ActiveListIdx     r_head, r_tail, w_head_next, w_tail_next, w_walk_idx;
    AlCount           r_count, w_count_next;
    logic [DEPTH-1:0] r_valid, r_done, r_mispredict;
    ActiveListEntry   r_entry [DEPTH];
    logic             w_alloc_fire, w_commit, w_walk, w_wb_hit;

    assign w_walk_idx  = r_tail - ActiveListIdx'(1);
    assign alloc_index = r_tail;
    // Writeback is only honoured in RUN and only for live entries.
    assign w_wb_hit    = (r_state == AL_RUN) & wb_valid & r_valid[wb_index];

    // Next-state, pointer arithmetic and all combinational outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_state_next     = r_state;
        w_head_next      = r_head;
        w_tail_next      = r_tail;
        w_count_next     = r_count;
        w_alloc_fire     = 1'b0;
        w_commit         = 1'b0;
        w_walk           = 1'b0;
        alloc_ready      = 1'b0;
        commit_valid     = 1'b0;
        commit_index     = '0;
        commit_uses_rw   = 1'b0;
        commit_arch_rd   = '0;
        commit_is_store  = 1'b0;
        free_valid       = 1'b0;
        free_preg        = '0;
        rollback_valid   = 1'b0;
        rollback_arch_rd = '0;
        rollback_preg    = '0;
        flush            = 1'b0;

        case (r_state)
            AL_RUN: begin
                alloc_ready  = (r_count != AlCount'(DEPTH));
                w_alloc_fire = alloc_valid & alloc_ready;
                w_commit     = (r_count != '0) & r_valid[r_head] & r_done[r_head];
                commit_valid = w_commit;
                if (w_commit) begin
                    commit_index    = r_head;
                    commit_uses_rw  = r_entry[r_head].uses_rw;
                    commit_arch_rd  = r_entry[r_head].arch_rd;
                    commit_is_store = r_entry[r_head].is_store;
                    free_valid      = r_entry[r_head].uses_rw;
                    free_preg       = r_entry[r_head].old_preg;
                end
                w_tail_next  = r_tail + ActiveListIdx'(w_alloc_fire);
                w_head_next  = r_head + ActiveListIdx'(w_commit);
                w_count_next = r_count + AlCount'(w_alloc_fire) - AlCount'(w_commit);
                // Anything still in the list behind a mispredicted branch is wrong-path.
                if (w_commit && r_mispredict[r_head] && (w_count_next != '0))
                    w_state_next = AL_WALK;
            end
            AL_WALK: begin
                flush            = 1'b1;
                w_walk           = 1'b1;
                rollback_valid   = r_entry[w_walk_idx].uses_rw;
                rollback_arch_rd = r_entry[w_walk_idx].arch_rd;
                rollback_preg    = r_entry[w_walk_idx].old_preg;
                free_valid       = r_entry[w_walk_idx].uses_rw;
                free_preg        = r_entry[w_walk_idx].new_preg;
                w_tail_next      = w_walk_idx;
                w_count_next     = r_count - AlCount'(1);
                if (w_walk_idx == r_head)
                    w_state_next = AL_RUN;
            end
        endcase
    end

    // State, pointers and per-entry status bits with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state      <= AL_RUN;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_done       <= '0;
            r_mispredict <= '0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            if (w_wb_hit) begin
                r_done[wb_index]       <= 1'b1;
                r_mispredict[wb_index] <= r_mispredict[wb_index] |
                                          (wb_mispredict & r_entry[wb_index].is_branch);
            end
            if (w_commit)
                r_valid[r_head] <= 1'b0;
            if (w_walk)
                r_valid[w_walk_idx] <= 1'b0;
            if (w_alloc_fire) begin
                r_valid[r_tail]      <= 1'b1;
                r_done[r_tail]       <= 1'b0;
                r_mispredict[r_tail] <= 1'b0;
            end
        end
    end

    // Entry payload, written once at allocation.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is only ever read behind a set valid bit, which is reset.
        if (w_alloc_fire)
            r_entry[r_tail] <= '{uses_rw:   alloc_uses_rw,
                                 arch_rd:   alloc_arch_rd,
                                 new_preg:  alloc_new_preg,
                                 old_preg:  alloc_old_preg,
                                 is_branch: alloc_is_branch,
                                 is_store:  alloc_is_store};
    end

endmodule

// File: tb/tb_active_list.sv
// Self-checking bench for active_list: table-driven alloc/writeback/commit
// vectors plus directed sequences for full/wrap, walk-back and reset mid-walk.
module tb_active_list;
    import active_list_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_valid;
    logic         alloc_ready;
    ActiveListIdx alloc_index;
    logic         alloc_uses_rw;
    MipsReg       alloc_arch_rd;
    PhysReg       alloc_new_preg;
    PhysReg       alloc_old_preg;
    logic         alloc_is_branch;
    logic         alloc_is_store;
    logic         wb_valid;
    ActiveListIdx wb_index;
    logic         wb_mispredict;
    logic         commit_valid;
    ActiveListIdx commit_index;
    logic         commit_uses_rw;
    MipsReg       commit_arch_rd;
    logic         commit_is_store;
    logic         free_valid;
    PhysReg       free_preg;
    logic         rollback_valid;
    MipsReg       rollback_arch_rd;
    PhysReg       rollback_preg;
    logic         flush;

    int n_checks = 0;
    int n_pass   = 0;

    active_list dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .alloc_uses_rw(alloc_uses_rw), .alloc_arch_rd(alloc_arch_rd),
        .alloc_new_preg(alloc_new_preg), .alloc_old_preg(alloc_old_preg),
        .alloc_is_branch(alloc_is_branch), .alloc_is_store(alloc_is_store),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_index(commit_index),
        .commit_uses_rw(commit_uses_rw), .commit_arch_rd(commit_arch_rd),
        .commit_is_store(commit_is_store),
        .free_valid(free_valid), .free_preg(free_preg),
        .rollback_valid(rollback_valid), .rollback_arch_rd(rollback_arch_rd),
        .rollback_preg(rollback_preg), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         av;
        logic         rw;
        MipsReg       rd;
        PhysReg       np;
        PhysReg       op;
        logic         wv;
        ActiveListIdx wi;
        logic         wm;
        logic         e_ready;
        ActiveListIdx e_aidx;
        logic         e_cv;
        ActiveListIdx e_cidx;
        MipsReg       e_crd;
        logic         e_fv;
        PhysReg       e_fp;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic av, input logic rw, input MipsReg rd,
                                input PhysReg np, input PhysReg op, input logic wv,
                                input ActiveListIdx wi, input logic wm, input logic e_ready,
                                input ActiveListIdx e_aidx, input logic e_cv,
                                input ActiveListIdx e_cidx, input MipsReg e_crd,
                                input logic e_fv, input PhysReg e_fp);
        vec_t v;
        v.av = av; v.rw = rw; v.rd = rd; v.np = np; v.op = op;
        v.wv = wv; v.wi = wi; v.wm = wm;
        v.e_ready = e_ready; v.e_aidx = e_aidx; v.e_cv = e_cv; v.e_cidx = e_cidx;
        v.e_crd = e_crd; v.e_fv = e_fv; v.e_fp = e_fp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_arch_rd = '0;
        alloc_new_preg = '0; alloc_old_preg = '0; alloc_is_branch = 1'b0; alloc_is_store = 1'b0;
        wb_valid = 1'b0; wb_index = '0; wb_mispredict = 1'b0;
    endtask

    task automatic set_alloc(input logic rw, input MipsReg rd, input PhysReg np,
                             input PhysReg op, input logic br);
        alloc_valid = 1'b1; alloc_uses_rw = rw; alloc_arch_rd = rd;
        alloc_new_preg = np; alloc_old_preg = op; alloc_is_branch = br; alloc_is_store = 1'b0;
    endtask

    task automatic set_wb(input ActiveListIdx idx, input logic mis);
        wb_valid = 1'b1; wb_index = idx; wb_mispredict = mis;
    endtask

    // Advance one clock; inputs are changed right after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset state.
        settle();
        check("rst_ready", alloc_ready, 1);
        check("rst_aidx", alloc_index, 0);
        check("rst_cv", commit_valid, 0);
        check("rst_fv", free_valid, 0);
        check("rst_fp", free_preg, 0);
        check("rst_flush", flush, 0);
        check("rst_rbv", rollback_valid, 0);

        // Three allocations, out-of-order writeback, in-order commit.
        vecs[0] = mk(1, 1, 5'd8,  6'd33, 6'd8,  0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 5'd0, 0, 6'd0);
        vecs[1] = mk(1, 1, 5'd9,  6'd34, 6'd9,  0, 5'd0, 0, 1, 5'd1, 0, 5'd0, 5'd0, 0, 6'd0);
        vecs[2] = mk(1, 1, 5'd10, 6'd35, 6'd10, 0, 5'd0, 0, 1, 5'd2, 0, 5'd0, 5'd0, 0, 6'd0);
        vecs[3] = mk(0, 0, 5'd0,  6'd0,  6'd0,  1, 5'd2, 0, 1, 5'd3, 0, 5'd0, 5'd0, 0, 6'd0);
        vecs[4] = mk(0, 0, 5'd0,  6'd0,  6'd0,  1, 5'd0, 0, 1, 5'd3, 0, 5'd0, 5'd0, 0, 6'd0);
        vecs[5] = mk(0, 0, 5'd0,  6'd0,  6'd0,  1, 5'd1, 0, 1, 5'd3, 1, 5'd0, 5'd8, 1, 6'd8);
        vecs[6] = mk(0, 0, 5'd0,  6'd0,  6'd0,  0, 5'd0, 0, 1, 5'd3, 1, 5'd1, 5'd9, 1, 6'd9);
        vecs[7] = mk(0, 0, 5'd0,  6'd0,  6'd0,  0, 5'd0, 0, 1, 5'd3, 1, 5'd2, 5'd10, 1, 6'd10);
        vecs[8] = mk(0, 0, 5'd0,  6'd0,  6'd0,  0, 5'd0, 0, 1, 5'd3, 0, 5'd0, 5'd0, 0, 6'd0);

        for (int i = 0; i < 9; i++) begin
            if (i == 3) check("t1_count3", 32'(dut.r_count), 3);
            if (vecs[i].av) set_alloc(vecs[i].rw, vecs[i].rd, vecs[i].np, vecs[i].op, 1'b0);
            if (vecs[i].wv) set_wb(vecs[i].wi, vecs[i].wm);
            settle();
            check($sformatf("v%0d_ready", i), alloc_ready, 32'(vecs[i].e_ready));
            check($sformatf("v%0d_aidx", i), alloc_index, 32'(vecs[i].e_aidx));
            check($sformatf("v%0d_cv", i), commit_valid, 32'(vecs[i].e_cv));
            check($sformatf("v%0d_flush", i), flush, 0);
            if (vecs[i].e_cv) begin
                check($sformatf("v%0d_cidx", i), commit_index, 32'(vecs[i].e_cidx));
                check($sformatf("v%0d_crd", i), commit_arch_rd, 32'(vecs[i].e_crd));
                check($sformatf("v%0d_fv", i), free_valid, 32'(vecs[i].e_fv));
                check($sformatf("v%0d_fp", i), free_preg, 32'(vecs[i].e_fp));
            end
            tick();
        end
        check("t2_count0", 32'(dut.r_count), 0);

        // Fill to 32, then commit while full and commit+alloc across the wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, MipsReg'(i), PhysReg'(i), PhysReg'(i + 32), 1'b0);
            settle();
            if (alloc_ready !== 1'b1) check($sformatf("t3_fill_ready%0d", i), alloc_ready, 1);
            tick();
        end
        settle();
        check("t3_full_ready", alloc_ready, 0);
        check("t3_full_aidx", alloc_index, 0);
        check("t3_full_count", 32'(dut.r_count), 32);
        set_wb(5'd0, 1'b0);
        alloc_valid = 1'b1;
        settle();
        check("t3_no_commit_yet", commit_valid, 0);
        tick();
        set_wb(5'd1, 1'b0);
        alloc_valid = 1'b1;
        settle();
        check("t3_fullc_cv", commit_valid, 1);
        check("t3_fullc_cidx", commit_index, 0);
        check("t3_fullc_ready", alloc_ready, 0);
        check("t3_fullc_fp", free_preg, 32);
        tick();
        set_alloc(1'b1, 5'd3, 6'd3, 6'd3, 1'b0);
        settle();
        check("t3_wrap_ready", alloc_ready, 1);
        check("t3_wrap_aidx", alloc_index, 0);
        check("t3_wrap_cv", commit_valid, 1);
        check("t3_wrap_cidx", commit_index, 1);
        check("t3_wrap_fp", free_preg, 33);
        tick();
        check("t3_count", 32'(dut.r_count), 31);
        check("t3_tail", 32'(dut.r_tail), 1);
        check("t3_head", 32'(dut.r_head), 2);

        // Mispredicted branch at idx4 with idx5..7 younger.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(1'b1, MipsReg'(i + 1), PhysReg'(40 + i), PhysReg'(20 + i), i == 4);
            settle();
            check($sformatf("t4_aidx%0d", i), alloc_index, 32'(i));
            tick();
        end
        for (int k = 0; k <= 4; k++) begin
            set_wb(ActiveListIdx'(k), k == 4);
            settle();
            check($sformatf("t4_cv_c%0d", k), commit_valid, 32'(k != 0));
            if (k != 0) begin
                check($sformatf("t4_cidx_c%0d", k), commit_index, 32'(k - 1));
                check($sformatf("t4_fp_c%0d", k), free_preg, 32'(20 + k - 1));
            end
            tick();
        end
        settle();
        check("t4_br_cv", commit_valid, 1);
        check("t4_br_cidx", commit_index, 4);
        check("t4_br_fp", free_preg, 24);
        check("t4_br_flush", flush, 0);
        tick();
        for (int j = 7; j >= 5; j--) begin
            if (j == 7) set_wb(5'd5, 1'b0);
            settle();
            check($sformatf("t4_w%0d_flush", j), flush, 1);
            check($sformatf("t4_w%0d_cv", j), commit_valid, 0);
            check($sformatf("t4_w%0d_ready", j), alloc_ready, 0);
            check($sformatf("t4_w%0d_rbv", j), rollback_valid, 1);
            check($sformatf("t4_w%0d_rbrd", j), rollback_arch_rd, 32'(j + 1));
            check($sformatf("t4_w%0d_rbp", j), rollback_preg, 32'(20 + j));
            check($sformatf("t4_w%0d_fv", j), free_valid, 1);
            check($sformatf("t4_w%0d_fp", j), free_preg, 32'(40 + j));
            tick();
        end
        settle();
        check("t4_run_flush", flush, 0);
        check("t4_run_rbv", rollback_valid, 0);
        check("t4_run_ready", alloc_ready, 1);
        check("t4_run_aidx", alloc_index, 5);
        check("t4_run_count", 32'(dut.r_count), 0);
        check("t5_walk_wb_ignored", 32'(dut.r_done[5]), 0);

        // Writeback to an empty index is ignored.
        set_wb(5'd12, 1'b0);
        tick();
        settle();
        check("t5_empty_cv", commit_valid, 0);
        check("t5_empty_done", 32'(dut.r_done[12]), 0);
        check("t5_empty_count", 32'(dut.r_count), 0);

        // Reset asserted during the second walk cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, MipsReg'(i + 1), PhysReg'(40 + i), PhysReg'(20 + i), i == 0);
            tick();
        end
        set_wb(5'd0, 1'b1);
        tick();
        settle();
        check("t6_commit_br", commit_valid, 1);
        tick();
        settle();
        check("t6_walk1_flush", flush, 1);
        check("t6_walk1_rbp", rollback_preg, 23);
        tick();
        rst_n = 1'b0;
        settle();
        check("t6_walk2_rbp", rollback_preg, 22);
        tick();
        rst_n = 1'b1;
        settle();
        check("t6_rst_count", 32'(dut.r_count), 0);
        check("t6_rst_flush", flush, 0);
        check("t6_rst_rbv", rollback_valid, 0);
        check("t6_rst_ready", alloc_ready, 1);
        check("t6_rst_aidx", alloc_index, 0);
        check("t6_rst_fv", free_valid, 0);
        tick();
        settle();
        check("t6_after_flush", flush, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
